// File: rtl/ay_mixer_dac_if.sv
// Bus between the turbosound channel source and the mixer/DAC stage.
// The master side supplies channel levels and control bits; the slave
// (the mixer) returns the latched PCM samples and the 1-bit DAC streams.
// pcm_valid is a one-cycle strobe with no back-pressure: the consumer must
// take pcm_l/pcm_r in the cycle pcm_valid is high, there is no ready.
interface ay_mixer_dac_if #(
   parameter int PCM_W = 11
);
   logic             en_ay;
   logic             en_ts;
   logic [1:0]       stereo;
   logic [7:0]       ay_a0;
   logic [7:0]       ay_b0;
   logic [7:0]       ay_c0;
   logic [7:0]       ay_a1;
   logic [7:0]       ay_b1;
   logic [7:0]       ay_c1;
   logic             beeper;
   logic             tape_out;
   logic             tape_in;
   logic [PCM_W-1:0] pcm_l;
   logic [PCM_W-1:0] pcm_r;
   logic             pcm_valid;
   logic             dac_l;
   logic             dac_r;

   modport master (
      output en_ay, en_ts, stereo,
      output ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1,
      output beeper, tape_out, tape_in,
      input  pcm_l, pcm_r, pcm_valid, dac_l, dac_r
   );

   modport slave (
      input  en_ay, en_ts, stereo,
      input  ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1,
      input  beeper, tape_out, tape_in,
      output pcm_l, pcm_r, pcm_valid, dac_l, dac_r
   );
endinterface

// File: rtl/ay_mixer_dac.sv
// AY/beeper/tape mixer with first-order sigma-delta outputs.
// An 8-slot counter walks the six AY channels, then the beeper/tape slot,
// accumulating left/right sums; slot 0 latches the sums as the new PCM
// sample. Each side then drives a 1-bit sigma-delta modulator.
module ay_mixer_dac #(
   parameter int BEEPER_WEIGHT = 384,
   parameter int TAPE_WEIGHT   = 64,
   parameter int PCM_W         = 11
) (
   input logic clk28,
   input logic rst,
   ay_mixer_dac_if.slave bus
);

   localparam logic [PCM_W-1:0] BEEP_W = PCM_W'(BEEPER_WEIGHT);
   localparam logic [PCM_W-1:0] TAPE_W = PCM_W'(TAPE_WEIGHT);

   typedef enum logic [1:0] {
      CH_A    = 2'd0,
      CH_B    = 2'd1,
      CH_C    = 2'd2,
      CH_NONE = 2'd3
   } channel_e;

   logic [2:0]       slot;
   logic [PCM_W-1:0] acc_l, acc_r;
   logic [PCM_W-1:0] pcm_l, pcm_r;
   logic             pcm_valid;
   logic [PCM_W:0]   sd_l, sd_r;
   logic             dac_l, dac_r;

   channel_e         ch;
   logic [7:0]       x;
   logic             chip_on;
   logic [PCM_W-1:0] xe, x2;
   logic [PCM_W-1:0] bonus;
   logic [PCM_W-1:0] add_l, add_r;

   // Select this slot's channel level and work out the per-side increments
   always_comb begin
      x       = 8'd0;
      ch      = CH_NONE;
      chip_on = 1'b0;
      case (slot)
         3'd1: begin x = bus.ay_a0; ch = CH_A; chip_on = bus.en_ay; end
         3'd2: begin x = bus.ay_b0; ch = CH_B; chip_on = bus.en_ay; end
         3'd3: begin x = bus.ay_c0; ch = CH_C; chip_on = bus.en_ay; end
         3'd4: begin x = bus.ay_a1; ch = CH_A; chip_on = bus.en_ay & bus.en_ts; end
         3'd5: begin x = bus.ay_b1; ch = CH_B; chip_on = bus.en_ay & bus.en_ts; end
         3'd6: begin x = bus.ay_c1; ch = CH_C; chip_on = bus.en_ay & bus.en_ts; end
         default: begin x = 8'd0; ch = CH_NONE; chip_on = 1'b0; end
      endcase

      xe    = {{(PCM_W-8){1'b0}}, x};
      x2    = {xe[PCM_W-2:0], 1'b0};
      bonus = (bus.beeper ? BEEP_W : '0)
            + ((bus.tape_out ^ bus.tape_in) ? TAPE_W : '0);

      add_l = '0;
      add_r = '0;
      if (slot == 3'd7) begin
         add_l = bonus;
         add_r = bonus;
      end else if (chip_on && ch != CH_NONE) begin
         case (bus.stereo)
            2'd0: begin
               // mono: every channel lands equally on both sides
               add_l = xe;
               add_r = xe;
            end
            2'd2: begin
               // ACB: A hard left, B hard right, C centre
               case (ch)
                  CH_A:    add_l = x2;
                  CH_B:    add_r = x2;
                  default: begin add_l = xe; add_r = xe; end
               endcase
            end
            default: begin
               // ABC (also the unused code 3): A left, C right, B centre
               case (ch)
                  CH_A:    add_l = x2;
                  CH_C:    add_r = x2;
                  default: begin add_l = xe; add_r = xe; end
               endcase
            end
         endcase
      end
   end

   // Slot counter, accumulators and the slot-0 sample latch
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         slot      <= 3'd0;
         acc_l     <= '0;
         acc_r     <= '0;
         pcm_l     <= '0;
         pcm_r     <= '0;
         pcm_valid <= 1'b0;
      end else begin
         slot <= slot + 3'd1;
         if (slot == 3'd0) begin
            pcm_l     <= acc_l;
            pcm_r     <= acc_r;
            pcm_valid <= 1'b1;
            acc_l     <= '0;
            acc_r     <= '0;
         end else begin
            pcm_valid <= 1'b0;
            acc_l     <= acc_l + add_l;
            acc_r     <= acc_r + add_r;
         end
      end
   end

   // First-order sigma-delta per side; the accumulator carry is the bit
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         sd_l  <= '0;
         sd_r  <= '0;
         dac_l <= 1'b0;
         dac_r <= 1'b0;
      end else begin
         sd_l  <= {1'b0, sd_l[PCM_W-1:0]} + {1'b0, pcm_l};
         sd_r  <= {1'b0, sd_r[PCM_W-1:0]} + {1'b0, pcm_r};
         dac_l <= sd_l[PCM_W];
         dac_r <= sd_r[PCM_W];
      end
   end

   assign bus.pcm_l     = pcm_l;
   assign bus.pcm_r     = pcm_r;
   assign bus.pcm_valid = pcm_valid;
   assign bus.dac_l     = dac_l;
   assign bus.dac_r     = dac_r;

endmodule

// File: tb/tb_ay_mixer_dac.sv
// Directed bench for ay_mixer_dac: mix weights per stereo mode, enables,
// beeper/tape bonus, full-scale case, pcm_valid cadence, sigma-delta
// density and mid-frame reset.
module tb_ay_mixer_dac;

   localparam int PCM_W = 11;

   int n_checks = 0;
   int n_fail   = 0;

   // clock / reset
   logic clk28 = 1'b0;
   logic rst   = 1'b1;
   always #5 clk28 = ~clk28;

   ay_mixer_dac_if #(.PCM_W(PCM_W)) bus ();

   ay_mixer_dac #(
      .BEEPER_WEIGHT(384),
      .TAPE_WEIGHT  (64),
      .PCM_W        (PCM_W)
   ) dut (
      .clk28(clk28),
      .rst  (rst),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // drive a full input vector just after a falling edge
   task automatic apply(input logic [1:0] st, input logic eay, input logic ets,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] c0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] c1,
                        input logic bp, input logic to, input logic ti);
      @(negedge clk28);
      bus.stereo = st;  bus.en_ay = eay; bus.en_ts = ets;
      bus.ay_a0 = a0;   bus.ay_b0 = b0;  bus.ay_c0 = c0;
      bus.ay_a1 = a1;   bus.ay_b1 = b1;  bus.ay_c1 = c1;
      bus.beeper = bp;  bus.tape_out = to; bus.tape_in = ti;
   endtask

   // wait for the next pcm_valid, bounded; returns falling edges elapsed
   task automatic wait_pulse(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk28);
         cyc++;
      end while (!bus.pcm_valid && cyc < 64);
      if (!bus.pcm_valid) check("pulse_timeout", 32'd0, 32'd1);
   endtask

   // skip the possibly mixed frame, then compare the clean one
   task automatic run_vec(input string tag, input int exp_l, input int exp_r);
      int cyc;
      wait_pulse(cyc);
      wait_pulse(cyc);
      check({tag, "_l"}, 32'(bus.pcm_l), 32'(exp_l));
      check({tag, "_r"}, 32'(bus.pcm_r), 32'(exp_r));
   endtask

   // count DAC ones over one full modulator period with pcm held
   task automatic count_dac(input string tag, input int exp_ones);
      int ones_l;
      int ones_r;
      ones_l = 0;
      ones_r = 0;
      repeat (4) @(negedge clk28);
      for (int i = 0; i < (1 << PCM_W); i++) begin
         @(negedge clk28);
         ones_l += int'(bus.dac_l);
         ones_r += int'(bus.dac_r);
      end
      check({tag, "_dac_l"}, 32'(ones_l), 32'(exp_ones));
      check({tag, "_dac_r"}, 32'(ones_r), 32'(exp_ones));
   endtask

   initial begin
      int cyc;
      bus.stereo = 2'd0; bus.en_ay = 1'b0; bus.en_ts = 1'b0;
      bus.ay_a0 = 8'd0;  bus.ay_b0 = 8'd0; bus.ay_c0 = 8'd0;
      bus.ay_a1 = 8'd0;  bus.ay_b1 = 8'd0; bus.ay_c1 = 8'd0;
      bus.beeper = 1'b0; bus.tape_out = 1'b0; bus.tape_in = 1'b0;

      // reset state
      repeat (3) @(negedge clk28);
      check("rst_pcm_l", 32'(bus.pcm_l), 32'd0);
      check("rst_pcm_r", 32'(bus.pcm_r), 32'd0);
      check("rst_valid", 32'(bus.pcm_valid), 32'd0);
      check("rst_dac_l", 32'(bus.dac_l), 32'd0);
      check("rst_dac_r", 32'(bus.dac_r), 32'd0);

      // release: slot 0 runs on the very next edge
      rst = 1'b0;
      wait_pulse(cyc);
      check("first_pulse_delay", 32'(cyc), 32'd1);

      // pcm_valid width and spacing
      @(negedge clk28);
      check("valid_width", 32'(bus.pcm_valid), 32'd0);
      wait_pulse(cyc);
      check("valid_spacing", 32'(cyc + 1), 32'd8);
      wait_pulse(cyc);
      check("valid_spacing2", 32'(cyc), 32'd8);

      // mono, single channel full scale
      apply(2'd0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      run_vec("mono_a0", 255, 255);
      count_dac("mono_a0", 255);

      // ABC then ACB
      apply(2'd1, 1'b1, 1'b1, 8'd100, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      run_vec("abc", 240, 40);
      apply(2'd2, 1'b1, 1'b1, 8'd100, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      run_vec("acb", 200, 80);

      // chip 1 gated by en_ts
      apply(2'd0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 1'b0, 1'b0, 1'b0);
      run_vec("ts_off", 0, 0);
      apply(2'd0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 1'b0, 1'b0, 1'b0);
      run_vec("ts_on", 600, 600);

      // stereo code 3 behaves as ABC; tape bits equal cancel
      apply(2'd3, 1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 8'd1, 8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
      run_vec("st3", 44, 88);

      // AY disabled: only beeper + tape remain
      apply(2'd3, 1'b0, 1'b1, 8'd10, 8'd20, 8'd30, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0, 1'b1);
      run_vec("ay_off", 448, 448);

      // tape alone
      apply(2'd0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      run_vec("tape", 64, 64);

      // full scale, no wrap
      apply(2'd1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
      run_vec("full", 1978, 1978);
      count_dac("full", 1978);

      // reset at slot 4 with a partial frame in the accumulators
      wait_pulse(cyc);
      repeat (3) @(posedge clk28);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_pcm_l", 32'(bus.pcm_l), 32'd0);
      check("mid_rst_pcm_r", 32'(bus.pcm_r), 32'd0);
      check("mid_rst_valid", 32'(bus.pcm_valid), 32'd0);
      check("mid_rst_dac_l", 32'(bus.dac_l), 32'd0);
      check("mid_rst_dac_r", 32'(bus.dac_r), 32'd0);
      repeat (2) @(negedge clk28);
      rst = 1'b0;
      wait_pulse(cyc);
      check("post_rst_delay", 32'(cyc), 32'd1);
      check("post_rst_pcm_l", 32'(bus.pcm_l), 32'd0);
      check("post_rst_pcm_r", 32'(bus.pcm_r), 32'd0);
      wait_pulse(cyc);
      check("post_rst_spacing", 32'(cyc), 32'd8);
      check("post_rst_full_l", 32'(bus.pcm_l), 32'd1978);
      check("post_rst_full_r", 32'(bus.pcm_r), 32'd1978);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ay_mixer_dac.md
Name: ay_mixer_dac

Overview:
- Downstream stage of the turbosound block.
- Consumes the six 8-bit AY channel levels from two chips, plus beeper and tape bits.
- Mixes them into left/right PCM words using a time-multiplexed 8-slot accumulator.
- Drives two first-order sigma-delta 1-bit outputs to the board's RC audio filters.

Parameters:
- BEEPER_WEIGHT, 384, value added to both sides when beeper=1.
- TAPE_WEIGHT, 64, value added to both sides when tape_out ^ tape_in = 1.
- PCM_W, 11, PCM/accumulator width; must satisfy 1530+BEEPER_WEIGHT+TAPE_WEIGHT < 2^PCM_W.

Ports:
- clk28  in  1  system clock (28 MHz)
- rst  in  1  asynchronous reset, active high
- en_ay  in  1  1 = AY chips contribute; 0 = AY contributions treated as 0
- en_ts  in  1  1 = chip 1 contributes; 0 = ay_a1/b1/c1 treated as 0
- stereo  in  2  0 = mono, 1 = ABC, 2 = ACB, 3 = treated as ABC
- ay_a0, ay_b0, ay_c0  in  8 each  chip 0 channel levels
- ay_a1, ay_b1, ay_c1  in  8 each  chip 1 channel levels
- beeper  in  1  ULA beeper bit
- tape_out  in  1  ULA tape-out bit
- tape_in  in  1  tape input bit
- pcm_l, pcm_r  out  PCM_W  latched mixed samples
- pcm_valid  out  1  one-clk28 pulse when pcm_l/pcm_r update
- dac_l, dac_r  out  1  sigma-delta bitstreams

Behaviour:
- Reset (async, rst=1) forces:
  - slot=0, acc_l=acc_r=0, pcm_l=pcm_r=0, pcm_valid=0
  - sd_l=sd_r=0, dac_l=dac_r=0
  - Release takes effect on the next clk28 edge.
- Slot counter: 3 bits, advances every clk28, wraps 7→0.
- Slot actions (X = input sampled on that clock, zero-extended to PCM_W):
  - slot 0: pcm_l<=acc_l, pcm_r<=acc_r, pcm_valid<=1; acc_l, acc_r <= 0.
  - slots 1..3: chip 0 channels A, B, C.
  - slots 4..6: chip 1 channels A, B, C; contribute 0 if en_ts=0.
  - slot 7: add BEEPER_WEIGHT·beeper + TAPE_WEIGHT·(tape_out^tape_in) to both accumulators.
  - If en_ay=0, slots 1..6 add 0.
- Per-channel weighting for AY slots:
  - mono: A, B, C each add X to both sides.
  - ABC: A adds 2X to L; C adds 2X to R; B adds X to both.
  - ACB: A adds 2X to L; B adds 2X to R; C adds X to both.
- pcm_valid is 1 only in the cycle after slot 0; 0 otherwise.
- Latency: a frame sampled in slots 1..7 appears on pcm_* on the clock following the next slot 0, i.e. a new sample every 8 clk28.
- Arithmetic: unsigned, no saturation needed. Max per side = 2·(2·255+255) + BEEPER_WEIGHT + TAPE_WEIGHT = 1978 at defaults, which fits in 11 bits.
- Sigma-delta, every clk28, per side:
  - sd <= {1'b0, sd[PCM_W-1:0]} + pcm (PCM_W+1 bits)
  - dac <= sd[PCM_W] (registered carry)
  - Over 2^PCM_W clocks with constant pcm, dac is high exactly pcm times.
- Input changes mid-frame: each input is sampled only in its own slot; no glitch filtering.
- Changing stereo or en_* mid-frame: a mixed frame is allowed; the next full frame is clean.
- Reset mid-frame discards the partial frame; pcm returns to 0.

Test Plan:
- mono, en_ay=1, en_ts=1, ay_a0=255, all else 0 → pcm_l=pcm_r=255 one frame after inputs settle. Over 2048 clocks, dac_l high exactly 255 times.
- ABC, ay_a0=100, ay_b0=40, ay_c0=0 → pcm_l=240, pcm_r=40. Switch to ACB → pcm_l=200, pcm_r=80.
- en_ts=0, ay_a1=ay_b1=ay_c1=200, chip 0 all 0 → pcm_l=pcm_r=0. Set en_ts=1 in mono → pcm_l=pcm_r=600.
- ABC, all six channels=255, beeper=1, tape_out=1, tape_in=0 → pcm_l=pcm_r=1978, no wrap. Over 2048 clocks, dac high 1978 times.
- Reset asserted at slot 4 with nonzero inputs → all outputs 0 immediately. After release, pcm_valid pulses every 8 clocks and the first pcm word is 0 (partial frame discarded).
- pcm_valid spacing check: pulses exactly every 8 clk28, width 1 cycle.
